uart_rx_sampler: RTL and testbench

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_rx_sampler.sv | 127 ++++++++++++
 tb/tb_uart_rx_sampler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x oversampled UART receiver with 3-sample majority voting per bit
// Ports: clk, nReset (async active-low), en (oversample tick, 16 per bit),
//        in (async serial line, idle high), data (last received word),
//        done (one-clk frame-complete pulse), err (bad-frame pulse, with done).
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit after the data.
module uart_rx_sampler #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 err
);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] IDX_LAST  = 3'(DATA_BITS - 1);
  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                 done_q, done_d, err_q, err_d;
  logic                 par_err_q, par_err_d;
  logic                 rx, maj, decide, wrap;
  always_comb begin
    rx        = sync_q[1];
    // third sample is the live value on the deciding tick
    maj       = (samp_q[0] & samp_q[1]) | (rx & (samp_q[0] | samp_q[1]));
    decide    = en && cnt_q == 4'd9;
    wrap      = en && cnt_q == LAST_TICK;
    state_d   = state_q;
    cnt_d     = en ? cnt_q + 4'd1 : cnt_q;
    idx_d     = idx_q;
    samp_d    = (en && cnt_q == 4'd7) ? {samp_q[1], rx} :
                (en && cnt_q == 4'd8) ? {rx, samp_q[0]} : samp_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    par_err_d = par_err_q;
    case (state_q)
      IDLE: begin
        cnt_d     = 4'd0;
        par_err_d = 1'b0;
        if (en && !rx) state_d = START;
      end
      START: begin
        if (decide && maj) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (wrap) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (decide) shreg_d[idx_q] = maj;
        if (wrap) begin
          idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == IDX_LAST) state_d = PARITY;
`else
          if (idx_q == IDX_LAST) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (decide) par_err_d = maj != ^shreg_q;
        if (wrap) state_d = STOP;
      end
`endif
      STOP: begin
        // leave on the decision tick so a back-to-back start is caught on the next en
        if (decide) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          data_d  = shreg_q;
          done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
          err_d   = !maj || par_err_q;
`else
          err_d   = !maj;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      cnt_q     <= 4'd0;
      idx_q     <= 3'd0;
      samp_q    <= 2'b11;
      shreg_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], in};
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      samp_q    <= samp_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      par_err_q <= par_err_d;
    end
  end
  assign data = data_q;
  assign done = done_q;
  assign err  = err_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: randomized frames checked against a tick-level reference model
module tb_uart_rx_sampler;
  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NB = DB + 1;
`else
  localparam int NB = DB;
`endif
  logic          clk = 1'b0, nReset = 1'b0, en = 1'b0, in = 1'b1;
  logic [DB-1:0] data;
  logic          done, err;
  int            tests = 0, fails = 0, dcnt = 0;
  bit            line[$];
  logic [DB-1:0] exp_data[$];
  bit            exp_err[$];
  uart_rx_sampler #(.DATA_BITS(DB)) dut (
    .clk(clk), .nReset(nReset), .en(en), .in(in),
    .data(data), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      dcnt++;
      if (exp_data.size() == 0) chk("spurious_done", 32'(done), 32'd0);
      else begin
        chk("data", 32'(data), 32'(exp_data.pop_front()));
        chk("err", 32'(err), 32'(exp_err.pop_front()));
      end
    end else if (err) chk("err_without_done", 32'(err), 32'd0);
  end
  // one oversample tick: line value settles, optional between-tick noise, then a single en pulse
  task automatic tick(input bit v, input bit noise);
    in = noise ? ~v : v;
    @(negedge clk);
    in = v;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask
  task automatic add_frame(input logic [7:0] d, input bit stop, input bit pflip, input int stop_len);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
    bits.push_back((^d) ^ pflip);
`else
    if (pflip) bits.push_back(stop);
    else bits.push_back(stop);
`endif
`ifdef UART_RX_PARITY_EN
    bits.push_back(stop);
`endif
    foreach (bits[i])
      for (int k = 0; k < ((i == bits.size() - 1) ? stop_len : 16); k++) line.push_back(bits[i]);
  endtask
  function automatic bit maj3(input int b);
    return (int'(line[b+7]) + int'(line[b+8]) + int'(line[b+9])) >= 2;
  endfunction
  // frame boundaries found by scanning the tick stream like a receiver would
  task automatic model();
    int pos;
    logic [DB-1:0] d;
    bit e;
    pos = 0;
    while (pos < line.size()) begin
      if (line[pos]) pos++;
      else if (maj3(pos)) pos += 10;
      else begin
        for (int b = 0; b < DB; b++) d[b] = maj3(pos + 16 * (b + 1));
        e = !maj3(pos + 16 * (NB + 1));
`ifdef UART_RX_PARITY_EN
        if (maj3(pos + 16 * (DB + 1)) != ^d) e = 1'b1;
`endif
        exp_data.push_back(d);
        exp_err.push_back(e);
        pos += 16 * (NB + 1) + 10;
      end
    end
  endtask
  task automatic run_line();
    int n;
    repeat (20) line.push_back(1'b1);
    model();
    n = exp_data.size();
    dcnt = 0;
    foreach (line[i]) tick(line[i], $urandom_range(7) == 0);
    repeat (8) @(negedge clk);
    chk("frames", 32'(dcnt), 32'(n));
    line.delete();
    exp_data.delete();
    exp_err.delete();
  endtask
  initial begin
    #2ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    int st, g;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    nReset = 1'b1;
    repeat (3) @(negedge clk);
    add_frame(8'h55, 1'b1, 1'b0, 16);
    run_line();
    add_frame(8'hA3, 1'b0, 1'b0, 16);
    run_line();
    repeat (5) line.push_back(1'b0);
    repeat (20) line.push_back(1'b1);
    add_frame(8'h0F, 1'b1, 1'b0, 16);
    run_line();
    st = line.size();
    add_frame(8'hC3, 1'b1, 1'b0, 16);
    line[st + 16 * 3 + 8] = 1'b1;
    run_line();
    add_frame(8'hFF, 1'b1, 1'b0, 16);
    dcnt = 0;
    for (int i = 0; i < 16 * 5 + 4; i++) tick(line[i], 1'b0);
    line.delete();
    nReset = 1'b0;
    @(negedge clk);
    chk("midreset_data", 32'(data), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_err", 32'(err), 32'd0);
    in = 1'b1;
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    repeat (4) @(negedge clk);
    chk("midreset_no_done", 32'(dcnt), 32'd0);
    add_frame(8'h12, 1'b1, 1'b0, 16);
    run_line();
`ifdef UART_RX_PARITY_EN
    add_frame(8'h07, 1'b1, 1'b1, 16);
    run_line();
`endif
    add_frame(8'h3C, 1'b1, 1'b0, 10);
    add_frame(8'h81, 1'b1, 1'b0, 10);
    run_line();
    for (int r = 0; r < 6; r++) begin
      for (int f = 0; f < 4; f++) begin
        repeat ($urandom_range(3)) line.push_back(1'b1);
        st = line.size();
        add_frame(8'($urandom_range(255)), $urandom_range(3) != 0, $urandom_range(3) == 0,
                  int'($urandom_range(16, 10)));
        if ($urandom_range(2) == 0) begin
          g = st + int'($urandom_range(16 * (NB + 1) + 9));
          line[g] = ~line[g];
        end
      end
      run_line();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
